// File: rtl/wb_sram_pkg.sv
// Shared types and window constants for the Wishbone SRAM bank controller.
package wb_sram_pkg;

  // Responder FSM: one macro access per Wishbone classic cycle.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACK    = 2'd3
  } state_e;

  // Byte-address field layout inside the 16 KiB window.
  localparam int unsigned WORD_LSB  = 2;
  localparam int unsigned BANK_LSB  = 11;
  localparam int unsigned BANK_BITS = 3;
  localparam int unsigned WIN_LSB   = 14;
  localparam int unsigned WIN_BYTES = 16384;
  localparam int unsigned MAX_BANKS = 8;

  // Read data returned for banks with no macro fitted.
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_sram_bank_ctrl.sv
// Wishbone classic responder for a bank of 1rw1r SRAM macros (port 0 only).
// Ports:
//   wb_clk_i, wb_rst_ni            clock, async active-low reset
//   wbs_cyc_i/stb_i/we_i/sel_i     Wishbone classic request
//   wbs_adr_i, wbs_dat_i           byte address, write data
//   wbs_ack_o, wbs_dat_o           one-cycle ack, read data (0 outside ack)
//   sram_csb0_o                    per-bank active-low chip select
//   sram_web0_o, sram_wmask0_o     shared write enable / byte mask
//   sram_addr0_o, sram_din0_o      shared word address / write data
//   sram_dout0_i                   concatenated port-0 read data, bank i at [i*DW +: DW]
module wb_sram_bank_ctrl
  import wb_sram_pkg::*;
#(
  parameter int unsigned          NUM_BANKS  = 5,
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          ADDR_WIDTH = 9,
  parameter logic [31:0]          BASE_ADDR  = 32'h3000_0000,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA  = DATA_WIDTH'(ERR_DATA_DEFAULT)
) (
  input  logic                            wb_clk_i,
  input  logic                            wb_rst_ni,
  input  logic                            wbs_stb_i,
  input  logic                            wbs_cyc_i,
  input  logic                            wbs_we_i,
  input  logic [3:0]                      wbs_sel_i,
  input  logic [31:0]                     wbs_adr_i,
  input  logic [DATA_WIDTH-1:0]           wbs_dat_i,
  output logic                            wbs_ack_o,
  output logic [DATA_WIDTH-1:0]           wbs_dat_o,
  output logic [NUM_BANKS-1:0]            sram_csb0_o,
  output logic                            sram_web0_o,
  output logic [3:0]                      sram_wmask0_o,
  output logic [ADDR_WIDTH-1:0]           sram_addr0_o,
  output logic [DATA_WIDTH-1:0]           sram_din0_o,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] sram_dout0_i
);

  state_e                  state_q, state_d;
  logic [BANK_BITS-1:0]    bank_q, bank_d;
  logic                    we_q, we_d;
  logic                    ack_d;
  logic [DATA_WIDTH-1:0]   dat_d;
  logic [NUM_BANKS-1:0]    csb_d;
  logic                    web_d;
  logic [3:0]              wmask_d;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic [DATA_WIDTH-1:0]   din_d;

  logic                    hit;
  logic [BANK_BITS-1:0]    req_bank;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   bank_dout [MAX_BANKS];
  logic                    unused_adr;

  // Byte offset within a word has no meaning for a word-wide macro.
  assign unused_adr = ^wbs_adr_i[1:0];

  // Request decode: claim only strobes that fall inside our 16 KiB window.
  assign hit      = wbs_cyc_i & wbs_stb_i &
                    (wbs_adr_i[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB]);
  assign req_bank = wbs_adr_i[BANK_LSB +: BANK_BITS];

  // Full 8-entry dout table so unfitted bank slots read back ERR_DATA directly.
  for (genvar g = 0; g < MAX_BANKS; g++) begin : g_dout
    if (g < NUM_BANKS) begin : g_pop
      assign bank_dout[g] = sram_dout0_i[g*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_unpop
      assign bank_dout[g] = ERR_DATA;
    end
  end

  assign rd_word = bank_dout[bank_q];

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    we_d    = we_q;
    ack_d   = 1'b0;
    dat_d   = '0;
    csb_d   = '1;
    web_d   = 1'b1;
    wmask_d = 4'h0;
    addr_d  = sram_addr0_o;
    din_d   = sram_din0_o;

    unique case (state_q)
      ST_IDLE: begin
        if (hit) begin
          state_d = ST_ACCESS;
          bank_d  = req_bank;
          we_d    = wbs_we_i;
          // Shifting past NUM_BANKS leaves every select released.
          csb_d   = ~(NUM_BANKS'(1) << req_bank);
          web_d   = ~wbs_we_i;
          wmask_d = wbs_sel_i;
          addr_d  = wbs_adr_i[WORD_LSB +: ADDR_WIDTH];
          din_d   = wbs_dat_i;
        end
      end
      ST_ACCESS: begin
        if (we_q) begin
          state_d = ST_ACK;
          ack_d   = wbs_cyc_i;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Macro dout has settled a full cycle after the select edge.
        state_d = ST_ACK;
        ack_d   = wbs_cyc_i;
        dat_d   = wbs_cyc_i ? rd_word : '0;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q       <= ST_IDLE;
      bank_q        <= '0;
      we_q          <= 1'b0;
      wbs_ack_o     <= 1'b0;
      wbs_dat_o     <= '0;
      sram_csb0_o   <= '1;
      sram_web0_o   <= 1'b1;
      sram_wmask0_o <= 4'h0;
      sram_addr0_o  <= '0;
      sram_din0_o   <= '0;
    end else begin
      state_q       <= state_d;
      bank_q        <= bank_d;
      we_q          <= we_d;
      wbs_ack_o     <= ack_d;
      wbs_dat_o     <= dat_d;
      sram_csb0_o   <= csb_d;
      sram_web0_o   <= web_d;
      sram_wmask0_o <= wmask_d;
      sram_addr0_o  <= addr_d;
      sram_din0_o   <= din_d;
    end
  end

endmodule

// File: tb/tb_wb_sram_bank_ctrl.sv
// Bench for wb_sram_bank_ctrl: behavioural SRAM macros on port 0, a
// transaction-level reference that schedules expected pin values per cycle,
// and a per-cycle compare process.
module tb_wb_sram_bank_ctrl;

  localparam int          NB   = 5;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] ERR  = 32'hDEAD_BEEF;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              stb, cyc, we;
  logic [3:0]        sel;
  logic [31:0]       adr, dat_w;
  logic              ack;
  logic [31:0]       dat_r;
  logic [NB-1:0]     csb;
  logic              web;
  logic [3:0]        wmask;
  logic [8:0]        addr;
  logic [31:0]       din;
  logic [NB*32-1:0]  dout;

  always #5 clk = ~clk;

  wb_sram_bank_ctrl #(
    .NUM_BANKS(NB), .DATA_WIDTH(32), .ADDR_WIDTH(9), .BASE_ADDR(BASE), .ERR_DATA(ERR)
  ) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat_w),
    .wbs_ack_o(ack), .wbs_dat_o(dat_r),
    .sram_csb0_o(csb), .sram_web0_o(web), .sram_wmask0_o(wmask),
    .sram_addr0_o(addr), .sram_din0_o(din), .sram_dout0_i(dout)
  );

  // Behavioural macros: read data appears one clock after a selected edge.
  logic [31:0] emu_mem [NB][512];
  logic [31:0] emu_q   [NB];

  always_comb begin
    for (int i = 0; i < NB; i++) dout[i*32 +: 32] = emu_q[i];
  end

  always @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (!csb[i]) begin
        if (!web) begin
          for (int b = 0; b < 4; b++)
            if (wmask[b]) emu_mem[i][addr][b*8 +: 8] <= din[b*8 +: 8];
        end else begin
          emu_q[i] <= emu_mem[i][addr];
        end
      end
    end
  end

  // Reference memory contents, updated per completed transaction.
  logic [31:0] ref_mem [NB][512];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=%h want=%h", nm, cyc_n, act, exp);
  endtask

  // Expected pin values keyed by cycle index (cycle c = after posedge number c).
  logic [NB-1:0] e_csb   [int];
  logic          e_web   [int];
  logic [3:0]    e_wmask [int];
  logic [8:0]    e_addr  [int];
  logic [31:0]   e_din   [int];
  logic          e_ack   [int];
  logic [31:0]   e_dat   [int];

  bit          run = 1'b0;
  logic [8:0]  cur_addr = '0;
  logic [31:0] cur_din = '0;
  logic [31:0] last_dat = '0;
  logic [3:0]  last_wmask = '0;
  logic [8:0]  last_addr = '0;
  int          ack_cnt = 0;
  int          csb_cnt = 0;

  // Per-cycle comparison of every DUT output against the scheduled expectation.
  always @(negedge clk) begin
    int c;
    logic [NB-1:0] x_csb;
    logic x_web, x_ack;
    logic [3:0] x_wmask;
    if (run) begin
      c = cyc_n;
      x_csb = '1; x_web = 1'b1; x_wmask = 4'h0; x_ack = 1'b0;
      if (!rst_n) begin
        cur_addr = '0;
        cur_din  = '0;
      end else begin
        if (e_csb.exists(c)) begin
          x_csb = e_csb[c]; x_web = e_web[c]; x_wmask = e_wmask[c];
          cur_addr = e_addr[c]; cur_din = e_din[c];
        end
        if (e_ack.exists(c)) x_ack = 1'b1;
      end
      chk("csb", 32'(csb), 32'(x_csb));
      chk("web", 32'(web), 32'(x_web));
      chk("wmask", 32'(wmask), 32'(x_wmask));
      chk("addr", 32'(addr), 32'(cur_addr));
      chk("din", din, cur_din);
      chk("ack", 32'(ack), 32'(x_ack));
      if (x_ack && e_dat.exists(c)) chk("rd_dat", dat_r, e_dat[c]);
      else if (!x_ack) chk("dat_idle", dat_r, 32'h0);
      if (ack) begin ack_cnt++; last_dat = dat_r; end
      if (csb != '1) begin csb_cnt++; last_wmask = wmask; last_addr = addr; end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drop();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  // One classic cycle issued from IDLE. abort_at=1 drops cyc after the hit
  // edge (ACCESS), abort_at=2 one edge later (WAIT for a read, ACK for a write).
  task automatic txn(input logic [31:0] a, input logic w, input logic [3:0] s,
                     input logic [31:0] d, input int abort_at);
    int k, bank, word, ack_c, n;
    logic [NB-1:0] oh;
    k = cyc_n + 1;
    bank = int'(a[13:11]);
    word = int'(a[10:2]);
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; dat_w = d;
    for (int i = 0; i < NB; i++) oh[i] = (i != bank);
    e_csb[k] = oh; e_web[k] = ~w; e_wmask[k] = s; e_addr[k] = 9'(word); e_din[k] = d;
    ack_c = k + (w ? 1 : 2);
    if (abort_at == 0 || abort_at > ack_c - k) begin
      e_ack[ack_c] = 1'b1;
      if (!w) e_dat[ack_c] = (bank < NB) ? ref_mem[bank][word] : ERR;
    end
    if (w && bank < NB) ref_mem[bank][word] = merge(ref_mem[bank][word], d, s);
    n = ack_c - k + 2;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      if (i == abort_at) drop();
    end
    drop();
  endtask

  task automatic miss(input logic [31:0] a, input int n);
    cyc = 1'b1; stb = 1'b1; we = 1'($urandom_range(0, 1)); adr = a;
    sel = 4'hF; dat_w = $urandom;
    idle(n);
    drop();
    idle(1);
  endtask

  // Write aborted by reset while its select is low; nothing may be stored.
  task automatic reset_during_write(input logic [31:0] a, input logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = a; dat_w = d;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_csb_now", 32'(csb), 32'(NB'('1)));
    chk("rst_ack_now", 32'(ack), 32'h0);
    chk("rst_web_now", 32'(web), 32'h1);
    drop();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);
  endtask

  initial begin
    int a0, c0, ab;
    logic [31:0] ra;
    for (int i = 0; i < NB; i++)
      for (int j = 0; j < 512; j++) begin
        emu_mem[i][j] = '0; ref_mem[i][j] = '0;
      end
    for (int i = 0; i < NB; i++) emu_q[i] = '0;
    drop(); sel = 4'h0; adr = '0; dat_w = '0;
    run = 1'b1;
    idle(2);
    chk("reset_ack", 32'(ack), 32'h0);
    chk("reset_dat", dat_r, 32'h0);
    chk("reset_csb", 32'(csb), 32'(NB'('1)));
    chk("reset_addr", 32'(addr), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Write then read, bank 0.
    c0 = csb_cnt;
    txn(32'h3000_0010, 1'b1, 4'hF, 32'hCAFE_F00D, 0);
    txn(32'h3000_0010, 1'b0, 4'hF, 32'h0, 0);
    chk("lit_b0_rd", last_dat, 32'hCAFE_F00D);
    chk("lit_b0_addr", 32'(last_addr), 32'd4);
    chk("lit_b0_pulses", 32'(csb_cnt - c0), 32'd2);

    // Byte-masked write, bank 4.
    txn(32'h3000_2000, 1'b1, 4'hF, 32'h1122_3344, 0);
    txn(32'h3000_2000, 1'b1, 4'b0101, 32'hAABB_CCDD, 0);
    chk("lit_b4_wmask", 32'(last_wmask), 32'h5);
    chk("lit_b4_model", ref_mem[4][0], 32'h11BB_33DD);
    txn(32'h3000_2000, 1'b0, 4'hF, 32'h0, 0);
    chk("lit_b4_rd", last_dat, 32'h11BB_33DD);

    // Unpopulated bank 5.
    c0 = csb_cnt;
    txn(32'h3000_2800, 1'b1, 4'hF, 32'h1234_5678, 0);
    txn(32'h3000_2800, 1'b0, 4'hF, 32'h0, 0);
    chk("lit_unpop_rd", last_dat, 32'hDEAD_BEEF);
    chk("lit_unpop_nocsb", 32'(csb_cnt - c0), 32'd0);

    // Out of window.
    a0 = ack_cnt; c0 = csb_cnt;
    miss(32'h3001_0000, 10);
    chk("lit_miss_noack", 32'(ack_cnt - a0), 32'd0);
    chk("lit_miss_nocsb", 32'(csb_cnt - c0), 32'd0);

    // Abort during WAIT, then a normal read.
    a0 = ack_cnt;
    txn(32'h3000_0010, 1'b0, 4'hF, 32'h0, 2);
    chk("lit_abort_noack", 32'(ack_cnt - a0), 32'd0);
    txn(32'h3000_0010, 1'b0, 4'hF, 32'h0, 0);
    chk("lit_abort_next", 32'(ack_cnt - a0), 32'd1);
    chk("lit_abort_rd", last_dat, 32'hCAFE_F00D);

    // Write with all byte selects clear leaves memory untouched.
    txn(32'h3000_0010, 1'b1, 4'h0, 32'h0BAD_F00D, 0);
    txn(32'h3000_0010, 1'b0, 4'hF, 32'h0, 0);
    chk("lit_sel0_rd", last_dat, 32'hCAFE_F00D);

    // Async reset during the ACCESS cycle of a write.
    txn(32'h3000_0810, 1'b1, 4'hF, 32'h5555_AAAA, 0);
    a0 = ack_cnt;
    reset_during_write(32'h3000_0810, 32'h0BAD_0BAD);
    chk("lit_rst_noack", 32'(ack_cnt - a0), 32'd0);
    txn(32'h3000_0810, 1'b0, 4'hF, 32'h0, 0);
    chk("lit_rst_rd", last_dat, 32'h5555_AAAA);

    // Randomised traffic over all eight bank slots and a few words each.
    for (int t = 0; t < 120; t++) begin
      if ($urandom_range(0, 7) == 0) begin
        miss({16'h3001 + 16'($urandom_range(0, 3)), 16'($urandom)}, $urandom_range(1, 4));
      end else begin
        ra = BASE | {18'h0, 3'($urandom_range(0, 7)), 6'h0, 3'($urandom_range(0, 7)),
                     2'($urandom_range(0, 3))};
        ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
        txn(ra, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, ab);
      end
      idle($urandom_range(0, 2));
    end

    idle(3);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
